// File: rtl/pixel_pack_wr.sv
// pixel_pack_wr -- binarizes a 12-bit grayscale pixel stream and packs the
// resulting bits, 16 per word, into sequential dmem writes for one frame.
//
// Parameters
//    THRESH         binarization threshold for 12-bit pixels
//    PIX_PER_FRAME  pixels captured per frame (multiple of 16)
//    BASE_ADDR      dmem word address of the first word written
//
// Ports
//    iCLK    in   1   clock, rising edge
//    iRST    in   1   asynchronous reset, active-high
//    iSTART  in   1   one-cycle request to arm capture of the next frame
//    iFVAL   in   1   frame valid
//    iDVAL   in   1   pixel valid; one pixel accepted per cycle when high
//    iDATA   in   12  grayscale pixel
//    oWREN   out  1   dmem write strobe, one cycle per word
//    oADDR   out  11  dmem word address (BASE_ADDR + word index, wraps)
//    oWDATA  out  16  packed word, first pixel of the group in bit 15
//    oBUSY   out  1   high while armed or capturing
//    oDONE   out  1   level, frame fully written
//    oSHORT  out  1   level, frame ended before PIX_PER_FRAME pixels
//
// Build option
//    PIXEL_PACK_INVERT_EN  when defined, a pixel bit is 1 for iDATA < THRESH
//                          (dark pixel is 1) instead of iDATA >= THRESH.

module pixel_pack_wr #(
   parameter logic [11:0] THRESH        = 12'h800,
   parameter int          PIX_PER_FRAME = 784,
   parameter logic [10:0] BASE_ADDR     = 11'd0
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iSTART,
   input  logic        iFVAL,
   input  logic        iDVAL,
   input  logic [11:0] iDATA,
   output logic        oWREN,
   output logic [10:0] oADDR,
   output logic [15:0] oWDATA,
   output logic        oBUSY,
   output logic        oDONE,
   output logic        oSHORT
);

   localparam int PCW = $clog2(PIX_PER_FRAME + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            fval_q;
   logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [15:0]     shift_q, shift_d;
   logic [10:0]     word_cnt_q, word_cnt_d;
   logic            short_flag_q, short_flag_d;
   logic            wren_q, wren_d;
   logic [10:0]     addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            short_q, short_d;

   logic            pix_bit;
   logic            accept;
   logic            last_pix;
   logic            group_full;
   logic [15:0]     shift_in;
   logic [15:0]     flush_word;

`ifdef PIXEL_PACK_INVERT_EN
   assign pix_bit = (iDATA < THRESH);
`else
   assign pix_bit = (iDATA >= THRESH);
`endif

   assign accept     = (state_q == S_CAPTURE) && iDVAL;
   assign last_pix   = (pix_cnt_q == PCW'(PIX_PER_FRAME - 1));
   assign group_full = (bit_cnt_q == 4'd15);
   assign shift_in   = {shift_q[14:0], pix_bit};
   // Held bits sit in the low end of shift_q; move them up so the first
   // pixel of the partial group lands in bit 15, zeros fill the rest.
   assign flush_word = shift_q << (5'd16 - {1'b0, bit_cnt_q});

   always_comb begin
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      word_cnt_d   = word_cnt_q;
      short_flag_d = short_flag_q;
      wren_d       = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      done_d       = done_q;
      short_d      = short_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (iSTART) begin
               state_d      = S_ARMED;
               pix_cnt_d    = '0;
               bit_cnt_d    = 4'd0;
               shift_d      = 16'd0;
               word_cnt_d   = 11'd0;
               short_flag_d = 1'b0;
               done_d       = 1'b0;
               short_d      = 1'b0;
            end else if (state_q == S_DONE) begin
               // Status levels follow one cycle after entering DONE.
               done_d  = 1'b1;
               short_d = short_flag_q;
            end
         end

         S_ARMED: begin
            // Only a fresh rise counts, so a frame already running is skipped.
            if (iFVAL && !fval_q) begin
               state_d = S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            if (accept) begin
               pix_cnt_d = pix_cnt_q + PCW'(1);
               if (group_full) begin
                  wren_d     = 1'b1;
                  wdata_d    = shift_in;
                  addr_d     = BASE_ADDR + word_cnt_q;
                  word_cnt_d = word_cnt_q + 11'd1;
                  bit_cnt_d  = 4'd0;
                  shift_d    = 16'd0;
               end else begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            // A pixel arriving with the iFVAL fall is taken above first;
            // if it was the last one the frame completes normally.
            if (accept && last_pix) begin
               state_d = S_DONE;
            end else if (!iFVAL) begin
               state_d = S_FLUSH;
            end
         end

         S_FLUSH: begin
            if (bit_cnt_q != 4'd0) begin
               wren_d     = 1'b1;
               wdata_d    = flush_word;
               addr_d     = BASE_ADDR + word_cnt_q;
               word_cnt_d = word_cnt_q + 11'd1;
               bit_cnt_d  = 4'd0;
               shift_d    = 16'd0;
            end
            short_flag_d = 1'b1;
            state_d      = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q      <= S_IDLE;
         fval_q       <= 1'b0;
         pix_cnt_q    <= '0;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 16'd0;
         word_cnt_q   <= 11'd0;
         short_flag_q <= 1'b0;
         wren_q       <= 1'b0;
         addr_q       <= BASE_ADDR;
         wdata_q      <= 16'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fval_q       <= iFVAL;
         pix_cnt_q    <= pix_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         word_cnt_q   <= word_cnt_d;
         short_flag_q <= short_flag_d;
         wren_q       <= wren_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         short_q      <= short_d;
      end
   end

   assign oWREN  = wren_q;
   assign oADDR  = addr_q;
   assign oWDATA = wdata_q;
   assign oBUSY  = busy_q;
   assign oDONE  = done_q;
   assign oSHORT = short_q;

endmodule

// File: tb/tb_pixel_pack_wr.sv
// Directed bench for pixel_pack_wr. A second instance with BASE_ADDR=2040
// shares the stimulus to exercise address wrap-around.
module tb_pixel_pack_wr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        fval = 1'b0;
   logic        dval = 1'b0;
   logic [11:0] data = 12'd0;

   logic        wren, busy, done, short_o;
   logic [10:0] addr;
   logic [15:0] wdata;
   logic        w_wren, w_busy, w_done, w_short;
   logic [10:0] w_addr;
   logic [15:0] w_wdata;

   int errors = 0;
   int checks = 0;

   logic [10:0] wa[$];
   logic [15:0] wd[$];
   logic [10:0] xa[$];
   logic [15:0] xd[$];

   always #5 clk = ~clk;

   pixel_pack_wr u_dut (
      .iCLK(clk), .iRST(rst), .iSTART(start), .iFVAL(fval), .iDVAL(dval),
      .iDATA(data), .oWREN(wren), .oADDR(addr), .oWDATA(wdata),
      .oBUSY(busy), .oDONE(done), .oSHORT(short_o)
   );

   pixel_pack_wr #(.BASE_ADDR(11'd2040)) u_wrap (
      .iCLK(clk), .iRST(rst), .iSTART(start), .iFVAL(fval), .iDVAL(dval),
      .iDATA(data), .oWREN(w_wren), .oADDR(w_addr), .oWDATA(w_wdata),
      .oBUSY(w_busy), .oDONE(w_done), .oSHORT(w_short)
   );

   // Log every write, sampled mid-cycle.
   always @(negedge clk) begin
      if (wren) begin
         wa.push_back(addr);
         wd.push_back(wdata);
         $display("  write dut  addr=%0d data=%h", addr, wdata);
      end
      if (w_wren) begin
         xa.push_back(w_addr);
         xd.push_back(w_wdata);
      end
   end

   task automatic clear_log();
      wa.delete(); wd.delete(); xa.delete(); xd.delete();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Rise iFVAL, one quiet cycle, n pixels alternating hi/lo, then drop iFVAL.
   // With fall_with_last set, the last pixel is driven together with the fall.
   task automatic send_frame(input int n, input logic [11:0] hi,
                             input logic [11:0] lo, input bit fall_with_last);
      @(negedge clk); fval = 1'b1; dval = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dval = 1'b1;
         data = (i % 2 == 0) ? hi : lo;
         if (fall_with_last && i == n - 1) fval = 1'b0;
      end
      @(negedge clk); dval = 1'b0; fval = 1'b0; data = 12'd0;
   endtask

   task automatic test_reset();
      idle(2);
      checks++;
      if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || short_o !== 1'b0 ||
          addr !== 11'd0 || wdata !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: wren=%b busy=%b done=%b short=%b addr=%0d data=%h, required all zero",
                  wren, busy, done, short_o, addr, wdata);
      end
      checks++;
      if (w_addr !== 11'd2040) begin
         errors++;
         $display("FAIL reset_wrap_addr: got %0d, required 2040", w_addr);
      end
      @(negedge clk); rst = 1'b0;
      idle(2);
      $display("test_reset done");
   endtask

   task automatic test_full_frame();
      logic [10:0] ea;
      clear_log();
      pulse_start();
      send_frame(784, 12'hFFF, 12'h000, 1'b0);
      idle(5);
      checks++;
      if (wa.size() != 49) begin
         errors++;
         $display("FAIL full_count: got %0d writes, required 49", wa.size());
      end
      for (int k = 0; k < wa.size(); k++) begin
         checks++;
         if (wa[k] !== 11'(k) || wd[k] !== 16'hAAAA) begin
            errors++;
            $display("FAIL full_word%0d: addr=%0d data=%h, required addr=%0d data=aaaa",
                     k, wa[k], wd[k], k);
         end
      end
      checks++;
      if (done !== 1'b1 || short_o !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_status: done=%b short=%b busy=%b, required 1 0 0", done, short_o, busy);
      end
      checks++;
      if (xa.size() != 49) begin
         errors++;
         $display("FAIL wrap_count: got %0d writes, required 49", xa.size());
      end
      for (int k = 0; k < xa.size(); k++) begin
         ea = 11'(2040 + k);
         checks++;
         if (xa[k] !== ea || xd[k] !== 16'hAAAA) begin
            errors++;
            $display("FAIL wrap_word%0d: addr=%0d data=%h, required addr=%0d data=aaaa",
                     k, xa[k], xd[k], ea);
         end
      end
      $display("test_full_frame done: %0d writes", wa.size());
   endtask

   task automatic test_midframe_start();
      clear_log();
      @(negedge clk); fval = 1'b1; dval = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); dval = 1'b1; data = 12'hFFF;
      end
      pulse_start();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); dval = 1'b1; data = 12'hFFF;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL midframe_armed: busy=%b done=%b, required 1 0", busy, done);
      end
      @(negedge clk); dval = 1'b0; fval = 1'b0;
      idle(3);
      checks++;
      if (wa.size() != 0) begin
         errors++;
         $display("FAIL midframe_skip: got %0d writes, required 0", wa.size());
      end
      send_frame(784, 12'hFFF, 12'h000, 1'b0);
      idle(5);
      checks++;
      if (wa.size() != 49 || done !== 1'b1 || short_o !== 1'b0) begin
         errors++;
         $display("FAIL midframe_next: writes=%0d done=%b short=%b, required 49 1 0",
                  wa.size(), done, short_o);
      end
      $display("test_midframe_start done: %0d writes", wa.size());
   endtask

   task automatic test_short();
      clear_log();
      pulse_start();
      send_frame(20, 12'hFFF, 12'hFFF, 1'b0);
      idle(6);
      checks++;
      if (wa.size() != 2) begin
         errors++;
         $display("FAIL short_count: got %0d writes, required 2", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 11'd0 || wd[0] !== 16'hFFFF || wa[1] !== 11'd1 || wd[1] !== 16'hF000) begin
            errors++;
            $display("FAIL short_words: %0d=%h %0d=%h, required 0=ffff 1=f000",
                     wa[0], wd[0], wa[1], wd[1]);
         end
      end
      checks++;
      if (done !== 1'b1 || short_o !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL short_status: done=%b short=%b busy=%b, required 1 1 0", done, short_o, busy);
      end
      $display("test_short done: %0d writes", wa.size());
   endtask

   task automatic test_fall_with_pixel();
      clear_log();
      pulse_start();
      send_frame(3, 12'hFFF, 12'hFFF, 1'b1);
      idle(6);
      checks++;
      if (wa.size() != 1) begin
         errors++;
         $display("FAIL fall_count: got %0d writes, required 1", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 11'd0 || wd[0] !== 16'hE000) begin
            errors++;
            $display("FAIL fall_word: addr=%0d data=%h, required 0 e000", wa[0], wd[0]);
         end
      end
      checks++;
      if (done !== 1'b1 || short_o !== 1'b1) begin
         errors++;
         $display("FAIL fall_status: done=%b short=%b, required 1 1", done, short_o);
      end
      $display("test_fall_with_pixel done");
   endtask

   task automatic test_threshold();
      logic [15:0] exp_w;
`ifdef PIXEL_PACK_INVERT_EN
      exp_w = 16'hAAAA;
`else
      exp_w = 16'h5555;
`endif
      clear_log();
      pulse_start();
      send_frame(16, 12'h7FF, 12'h800, 1'b0);
      idle(6);
      checks++;
      if (wa.size() != 1) begin
         errors++;
         $display("FAIL thresh_count: got %0d writes, required 1", wa.size());
      end else begin
         checks++;
         if (wd[0] !== exp_w || wa[0] !== 11'd0) begin
            errors++;
            $display("FAIL thresh_word: addr=%0d data=%h, required 0 %h", wa[0], wd[0], exp_w);
         end
      end
      checks++;
      if (done !== 1'b1 || short_o !== 1'b1) begin
         errors++;
         $display("FAIL thresh_status: done=%b short=%b, required 1 1", done, short_o);
      end
      $display("test_threshold done");
   endtask

   task automatic test_reset_mid();
      clear_log();
      pulse_start();
      @(negedge clk); fval = 1'b1; dval = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); dval = 1'b1; data = 12'hFFF;
      end
      @(negedge clk);
      checks++;
      if (wa.size() != 6) begin
         errors++;
         $display("FAIL rstmid_before: got %0d writes, required 6", wa.size());
      end
      rst = 1'b1;
      #1;
      checks++;
      if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || short_o !== 1'b0 ||
          addr !== 11'd0 || wdata !== 16'd0 || w_addr !== 11'd2040) begin
         errors++;
         $display("FAIL rstmid_async: wren=%b busy=%b done=%b short=%b addr=%0d data=%h waddr=%0d, required zeros and 2040",
                  wren, busy, done, short_o, addr, wdata, w_addr);
      end
      clear_log();
      idle(2);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); dval = 1'b1; data = 12'hFFF;
      end
      @(negedge clk); dval = 1'b0; fval = 1'b0;
      idle(3);
      checks++;
      if (wa.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_quiet: writes=%0d busy=%b done=%b, required 0 0 0", wa.size(), busy, done);
      end
      pulse_start();
      send_frame(784, 12'hFFF, 12'h000, 1'b0);
      idle(5);
      checks++;
      if (wa.size() != 49) begin
         errors++;
         $display("FAIL rstmid_count: got %0d writes, required 49", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 11'd0 || wa[48] !== 11'd48 || wd[0] !== 16'hAAAA) begin
            errors++;
            $display("FAIL rstmid_addr: first=%0d last=%0d data=%h, required 0 48 aaaa",
                     wa[0], wa[48], wd[0]);
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_midframe_start();
      test_short();
      test_fall_with_pixel();
      test_threshold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
